seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment vectors are a..g in bits 0..6, active high.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } seg_state_e;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_A = 7'h01;
  localparam logic [SEG_W-1:0] SEG_B = 7'h02;
  localparam logic [SEG_W-1:0] SEG_C = 7'h04;
  localparam logic [SEG_W-1:0] SEG_D = 7'h08;
  localparam logic [SEG_W-1:0] SEG_E = 7'h10;
  localparam logic [SEG_W-1:0] SEG_F = 7'h20;
  localparam logic [SEG_W-1:0] SEG_G = 7'h40;

  // Entry N is the glyph for hex digit N (listed F down to 0).
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    SEG_A | SEG_E | SEG_F | SEG_G,
    SEG_A | SEG_D | SEG_E | SEG_F | SEG_G,
    SEG_B | SEG_C | SEG_D | SEG_E | SEG_G,
    SEG_A | SEG_D | SEG_E | SEG_F,
    SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,
    SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G,
    SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G,
    SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,
    SEG_A | SEG_B | SEG_C,
    SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,
    SEG_A | SEG_C | SEG_D | SEG_F | SEG_G,
    SEG_B | SEG_C | SEG_F | SEG_G,
    SEG_A | SEG_B | SEG_C | SEG_D | SEG_G,
    SEG_A | SEG_B | SEG_D | SEG_E | SEG_G,
    SEG_B | SEG_C,
    SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = HEX_SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a dark gap between digits.
// Optional macro SEG_SCAN_DIMMING_EN adds i_bright PWM dimming of digit enables.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DWELL = 750,
  parameter int unsigned BLANK = 16,
  parameter int unsigned CBITS = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [2:0]       i_wr_idx,
  input  logic [3:0]       i_wr_data,
  input  logic             i_wr_dp,
`ifdef SEG_SCAN_DIMMING_EN
  input  logic [2:0]       i_bright,
`endif
  output logic [SEG_W-1:0] o_segment,
  output logic             o_dp,
  output logic [NDIG-1:0]  o_digit_en,
  output logic             o_frame_tick
);

  localparam int unsigned IW = 3;

  seg_state_e       r_state, w_state_nx;
  logic [CBITS-1:0] r_cnt, w_cnt_nx;
  logic [IW-1:0]    r_idx, w_idx_nx;
  logic             w_tick_nx;
  logic [3:0]       r_nib [8];
  logic [7:0]       r_ndp;
  logic [SEG_W-1:0] w_seg;
  logic [NDIG-1:0]  w_en_nx;
  logic             w_wr_fire;

  // The digit on display is locked against writes so its glyph stays stable.
  assign o_wr_ready = !i_rst && !(r_state == ST_SHOW && i_wr_idx == r_idx);
  assign w_wr_fire  = i_wr_valid && o_wr_ready && ({1'b0, i_wr_idx} < 4'(NDIG));

  seg_hex_decode u_hex_decode (
    .i_nib (r_nib[r_idx]),
    .o_seg (w_seg)
  );

`ifdef SEG_SCAN_DIMMING_EN
  assign w_en_nx = (w_cnt_nx[2:0] <= i_bright) ? (NDIG'(1) << r_idx) : '0;
`else
  assign w_en_nx = NDIG'(1) << r_idx;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CBITS'(1);
    w_idx_nx   = r_idx;
    w_tick_nx  = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == CBITS'(BLANK - 1)) begin
          w_state_nx = ST_SHOW;
          w_cnt_nx   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == CBITS'(DWELL - 1)) begin
          w_state_nx = ST_BLANK;
          w_cnt_nx   = '0;
          w_idx_nx   = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
          w_tick_nx  = (r_idx == IW'(NDIG - 1));
        end
      end
      default: begin
        w_state_nx = ST_BLANK;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_ndp        <= '0;
      for (int i = 0; i < 8; i++) r_nib[i] <= '0;
      o_segment    <= '0;
      o_dp         <= 1'b0;
      o_digit_en   <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      o_frame_tick <= w_tick_nx;
      if (w_wr_fire) begin
        r_nib[i_wr_idx] <= i_wr_data;
        r_ndp[i_wr_idx] <= i_wr_dp;
      end
      // Glyph is captured once on SHOW entry and held for the whole dwell.
      if (w_state_nx == ST_SHOW) begin
        if (r_state == ST_BLANK) begin
          o_segment <= w_seg;
          o_dp      <= r_ndp[r_idx];
        end
        o_digit_en <= w_en_nx;
      end else begin
        o_segment  <= '0;
        o_dp       <= 1'b0;
        o_digit_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: expected outputs come from a
// time-position model (cycles since reset mapped onto the scan frame).
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DW   = 750;
  localparam int BLK  = 16;
  localparam int CB   = 10;
  localparam int P    = BLK + DW;
  localparam int FR   = NDIG * P;
  localparam int OW   = 9 + NDIG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      wr_idx;
  logic [3:0]      wr_data;
  logic            wr_dp;
  logic [6:0]      segment;
  logic            dp;
  logic [NDIG-1:0] digit_en;
  logic            frame_tick;
`ifdef SEG_SCAN_DIMMING_EN
  logic [2:0]      bright;
`endif

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DW), .BLANK(BLK), .CBITS(CB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_idx     (wr_idx),
    .i_wr_data    (wr_data),
    .i_wr_dp      (wr_dp),
`ifdef SEG_SCAN_DIMMING_EN
    .i_bright     (bright),
`endif
    .o_segment    (segment),
    .o_dp         (dp),
    .o_digit_en   (digit_en),
    .o_frame_tick (frame_tick)
  );

  int checks = 0;
  int errors = 0;

  // Model: n = clock edges since reset released; stored digits; latched glyph.
  int         n = 0;
  logic [3:0] m_reg [8];
  logic       m_dp  [8];
  logic [3:0] m_shown;
  logic       m_shown_dp;
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int pos();  return n % FR;      endfunction
  function automatic int dig();  return pos() / P;   endfunction
  function automatic int rin();  return pos() % P;   endfunction
  function automatic logic showing(); return rin() >= BLK; endfunction

  function automatic logic exp_ready();
    return !rst && !(showing() && int'(wr_idx) == dig());
  endfunction

  function automatic logic [OW-1:0] exp_out();
    logic [6:0] s; logic d; logic [NDIG-1:0] e; logic t;
    s = '0; d = 1'b0; e = '0;
    t = (n > 0) && (pos() == 0);
    if (showing()) begin
      s = hex7[m_shown];
      d = m_shown_dp;
      e = NDIG'(1) << dig();
`ifdef SEG_SCAN_DIMMING_EN
      if (((rin() - BLK) % 8) > int'(bright)) e = '0;
`endif
    end
    return {s, d, e, t};
  endfunction

  // Advance one clock and move the model along; no checking here.
  task automatic tick();
    logic acc;
    acc = wr_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      n = 0;
      for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_dp[i] = 1'b0; end
    end else begin
      n++;
      if (rin() == BLK) begin m_shown = m_reg[dig()]; m_shown_dp = m_dp[dig()]; end
      if (acc && int'(wr_idx) < NDIG) begin m_reg[wr_idx] = wr_data; m_dp[wr_idx] = wr_dp; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_data = '0; wr_dp = 1'b0;
    repeat (3) begin
      tick();
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wr_ready); end
      checks++;
      if ({segment, dp, digit_en, frame_tick} !== OW'(0)) begin
        errors++; $display("FAIL reset_outs got %h exp 0", {segment, dp, digit_en, frame_tick});
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  task automatic test_digits();
    for (int i = 0; i < NDIG; i++) begin
      wr_valid = 1'b1; wr_idx = 3'(i); wr_data = 4'(i + 1); wr_dp = 1'b0;
      #1;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL digits_ready i=%0d got %b exp 1", i, wr_ready); end
      checks++;
      tick();
    end
    wr_valid = 1'b0;
    while (n <= FR) begin
      tick();
      if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
        errors++; $display("FAIL digits_scan n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
      end
      checks++;
      if (n == BLK + 1) begin
        if (segment !== 7'h06 || digit_en !== NDIG'(1)) begin
          errors++; $display("FAIL digit0_glyph got seg %h en %b exp 06 0001", segment, digit_en);
        end
        checks++;
      end
    end
  endtask

  task automatic test_frame_period();
    int k, gap;
    k = 0;
    while (frame_tick !== 1'b1 && k < 2 * FR) begin tick(); k++; end
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL frame_wait got timeout exp tick"); end
    checks++;
    gap = 0;
    do begin tick(); gap++; end while (frame_tick !== 1'b1 && gap < 2 * FR);
    if (gap !== 3064) begin errors++; $display("FAIL frame_period got %0d exp 3064", gap); end
    checks++;
  endtask

  task automatic test_blocked_write();
    int k; logic [3:0] v; logic acc_seen;
    k = 0;
    while (!(dig() == 0 && rin() == BLK + 100) && k < 2 * FR) begin tick(); k++; end
    if (!(dig() == 0 && rin() == BLK + 100)) begin errors++; $display("FAIL blk_wait got timeout exp show0"); end
    checks++;
    v = m_reg[0] + 4'(1 + $urandom_range(0, 14));
    wr_valid = 1'b1; wr_idx = 3'd0; wr_data = v; wr_dp = 1'($urandom);
    acc_seen = 1'b0;
    k = 0;
    while (!acc_seen && k < P) begin
      #1;
      if (wr_ready !== exp_ready()) begin errors++; $display("FAIL blk_ready n=%0d got %b exp %b", n, wr_ready, exp_ready()); end
      checks++;
      if (wr_ready === 1'b1) begin
        acc_seen = 1'b1;
        if (!(dig() == 1 && rin() == 0)) begin errors++; $display("FAIL blk_accept_cycle got r=%0d d=%0d exp r=0 d=1", rin(), dig()); end
        checks++;
      end
      tick(); k++;
      if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
        errors++; $display("FAIL blk_outs n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
      end
      checks++;
    end
    wr_valid = 1'b0;
    k = 0;
    while (!(dig() == 0 && rin() == BLK) && k < 2 * FR) begin
      tick(); k++;
      if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
        errors++; $display("FAIL blk_run n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
      end
      checks++;
    end
    if (segment !== hex7[v]) begin errors++; $display("FAIL blk_new_glyph got %h exp %h", segment, hex7[v]); end
    checks++;
  endtask

  task automatic test_bad_idx();
    wr_valid = 1'b1; wr_idx = 3'd5; wr_data = 4'hF; wr_dp = 1'b1;
    #1;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL badidx_ready got %b exp 1", wr_ready); end
    checks++;
    tick();
    wr_valid = 1'b0;
    repeat (FR) begin
      tick();
      if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
        errors++; $display("FAIL badidx_outs n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    repeat (2 * FR) begin
      wr_valid = 1'($urandom); wr_idx = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom); wr_dp = 1'($urandom);
      #1;
      if (wr_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, wr_ready, exp_ready()); end
      checks++;
      tick();
      if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
        errors++; $display("FAIL rand_outs n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
      end
      checks++;
    end
    wr_valid = 1'b0;
  endtask

`ifdef SEG_SCAN_DIMMING_EN
  task automatic test_dimming();
    int k, on, expect_on;
    for (int b = 3; b <= 7; b += 4) begin
      bright = 3'(b);
      k = 0;
      while (rin() != BLK - 1 && k < FR) begin tick(); k++; end
      on = 0;
      repeat (DW) begin
        tick();
        if (digit_en !== '0) on++;
        if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
          errors++; $display("FAIL dim_outs n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
        end
        checks++;
      end
      expect_on = (DW / 8) * (b + 1) + (((DW % 8) < (b + 1)) ? (DW % 8) : (b + 1));
      if (on !== expect_on) begin errors++; $display("FAIL dim_duty b=%0d got %0d exp %0d", b, on, expect_on); end
      checks++;
    end
    bright = 3'd7;
  endtask
`endif

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (!(dig() == 2 && rin() == BLK + 50) && k < 2 * FR) begin tick(); k++; end
    if (!(dig() == 2 && rin() == BLK + 50)) begin errors++; $display("FAIL rmid_wait got timeout exp show2"); end
    checks++;
    rst = 1'b1; wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 4'h9; wr_dp = 1'b1;
    #1;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", wr_ready); end
    checks++;
    tick();
    if ({segment, dp, digit_en, frame_tick} !== OW'(0)) begin
      errors++; $display("FAIL rmid_dark got %h exp 0", {segment, dp, digit_en, frame_tick});
    end
    checks++;
    rst = 1'b0; wr_valid = 1'b0;
    repeat (BLK + 3) begin
      tick();
      if ({segment, dp, digit_en, frame_tick} !== exp_out()) begin
        errors++; $display("FAIL rmid_outs n=%0d got %h exp %h", n, {segment, dp, digit_en, frame_tick}, exp_out());
      end
      checks++;
      if (n == BLK) begin
        if (segment !== 7'h3F || dp !== 1'b0 || digit_en !== NDIG'(1)) begin
          errors++; $display("FAIL rmid_digit0 got seg %h dp %b en %b exp 3f 0 0001", segment, dp, digit_en);
        end
        checks++;
      end
    end
  endtask

  initial begin
`ifdef SEG_SCAN_DIMMING_EN
    bright = 3'd7;
`endif
    test_reset();
    test_digits();
    test_frame_period();
    test_blocked_write();
    test_bad_idx();
    test_random();
`ifdef SEG_SCAN_DIMMING_EN
    test_dimming();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
